// File: rtl/mvm_pkg.sv
// Shared constants and FSM state encoding for the mat_vec_mult sequencer.
package mvm_pkg;

  localparam int unsigned MVM_DEPTH      = 8;
  localparam int unsigned MVM_DATA_WIDTH = 8;
  localparam int unsigned MVM_NUM_ROWS   = 8;
  localparam int unsigned MVM_MAC_LAT    = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } mvm_state_e;

endpackage

// File: rtl/mvm_skew_gen.sv
// Skewed FIFO read-enable pattern for the systolic MAC chain, indexed by RUN-phase time t.
module mvm_skew_gen #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned NUM_ROWS = 8,
  parameter int unsigned CNT_W    = 5
) (
  input  logic [CNT_W-1:0]    i_t,
  output logic [NUM_ROWS-1:0] o_a_rden_c,
  output logic                o_b_rden_c
);

  always_comb begin
    o_b_rden_c = (i_t < CNT_W'(DEPTH));
    for (int unsigned i = 0; i < NUM_ROWS; i++) begin
      o_a_rden_c[i] = (i_t >= CNT_W'(i)) && (i_t < CNT_W'(i + DEPTH));
    end
  end

endmodule

// File: rtl/mvm_ctrl.sv
// Host-facing sequencer: loads A/B FIFOs over valid/ready, then drives skewed reads
// through the MAC chain and flags completion.
module mvm_ctrl
  import mvm_pkg::*;
#(
  parameter int unsigned DEPTH      = MVM_DEPTH,
  parameter int unsigned DATA_WIDTH = MVM_DATA_WIDTH,
  parameter int unsigned NUM_ROWS   = MVM_NUM_ROWS,
  parameter int unsigned MAC_LAT    = MVM_MAC_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a [NUM_ROWS-1:0],
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  a_wren,
  output logic                  b_wren,
  output logic [DATA_WIDTH-1:0] a_fifo_in [NUM_ROWS-1:0],
  output logic [DATA_WIDTH-1:0] b_fifo_in,
  output logic [NUM_ROWS-1:0]   a_rden,
  output logic                  b_rden,
  output logic                  clr,
  output logic                  busy,
  output logic                  done,
  output logic                  result_valid
);

  localparam int unsigned CNT_W = $clog2(DEPTH + NUM_ROWS) + 1;

  mvm_state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_beat_cnt, w_beat_nxt;
  logic [CNT_W-1:0]      r_t, w_t_nxt;
  logic [CNT_W-1:0]      r_d, w_d_nxt;
  logic                  w_hs;

  logic                  r_wren, w_wren_nxt;
  logic [DATA_WIDTH-1:0] r_a_fifo_in [NUM_ROWS-1:0];
  logic [DATA_WIDTH-1:0] w_a_fifo_nxt [NUM_ROWS-1:0];
  logic [DATA_WIDTH-1:0] r_b_fifo_in, w_b_fifo_nxt;
  logic [NUM_ROWS-1:0]   r_a_rden, w_a_rden_nxt, w_skew_a;
  logic                  r_b_rden, w_b_rden_nxt, w_skew_b;
  logic                  r_clr, w_clr_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_result_valid, w_rv_nxt;

  assign in_ready = (r_state == LOAD);
  assign w_hs     = in_valid && in_ready;

  // Skew is evaluated on the next t so registered enables line up with the RUN cycle they belong to.
  mvm_skew_gen #(
    .DEPTH    (DEPTH),
    .NUM_ROWS (NUM_ROWS),
    .CNT_W    (CNT_W)
  ) u_skew (
    .i_t        (w_t_nxt),
    .o_a_rden_c (w_skew_a),
    .o_b_rden_c (w_skew_b)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_beat_nxt   = r_beat_cnt;
    w_t_nxt      = r_t;
    w_d_nxt      = r_d;
    w_rv_nxt     = r_result_valid;
    w_a_fifo_nxt = r_a_fifo_in;
    w_b_fifo_nxt = r_b_fifo_in;
    w_wren_nxt   = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = CLEAR;
          w_rv_nxt    = 1'b0;
        end
      end
      CLEAR: begin
        w_beat_nxt  = '0;
        w_state_nxt = LOAD;
      end
      LOAD: begin
        if (w_hs) begin
          w_wren_nxt   = 1'b1;
          w_a_fifo_nxt = in_a;
          w_b_fifo_nxt = in_b;
          w_beat_nxt   = r_beat_cnt + CNT_W'(1);
          if (r_beat_cnt == CNT_W'(DEPTH - 1)) begin
            w_state_nxt = RUN;
            w_t_nxt     = '0;
          end
        end
      end
      RUN: begin
        if (r_t == CNT_W'(DEPTH + NUM_ROWS - 2)) begin
          w_state_nxt = DRAIN;
          w_d_nxt     = '0;
        end else begin
          w_t_nxt = r_t + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (r_d == CNT_W'(MAC_LAT - 1)) begin
          w_state_nxt = DONE;
        end else begin
          w_d_nxt = r_d + CNT_W'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_clr_nxt    = (w_state_nxt == CLEAR);
    w_busy_nxt   = (w_state_nxt != IDLE);
    w_done_nxt   = (w_state_nxt == DONE);
    w_a_rden_nxt = (w_state_nxt == RUN) ? w_skew_a : '0;
    w_b_rden_nxt = (w_state_nxt == RUN) && w_skew_b;
    if (w_state_nxt == DONE) begin
      w_rv_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_beat_cnt     <= '0;
      r_t            <= '0;
      r_d            <= '0;
      r_wren         <= 1'b0;
      r_a_fifo_in    <= '{default: '0};
      r_b_fifo_in    <= '0;
      r_a_rden       <= '0;
      r_b_rden       <= 1'b0;
      r_clr          <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_beat_cnt     <= w_beat_nxt;
      r_t            <= w_t_nxt;
      r_d            <= w_d_nxt;
      r_wren         <= w_wren_nxt;
      r_a_fifo_in    <= w_a_fifo_nxt;
      r_b_fifo_in    <= w_b_fifo_nxt;
      r_a_rden       <= w_a_rden_nxt;
      r_b_rden       <= w_b_rden_nxt;
      r_clr          <= w_clr_nxt;
      r_busy         <= w_busy_nxt;
      r_done         <= w_done_nxt;
      r_result_valid <= w_rv_nxt;
    end
  end

  assign a_wren       = r_wren;
  assign b_wren       = r_wren;
  assign a_fifo_in    = r_a_fifo_in;
  assign b_fifo_in    = r_b_fifo_in;
  assign a_rden       = r_a_rden;
  assign b_rden       = r_b_rden;
  assign clr          = r_clr;
  assign busy         = r_busy;
  assign done         = r_done;
  assign result_valid = r_result_valid;

endmodule

// File: tb/tb_mvm_ctrl.sv
// Directed bench for mvm_ctrl with a small FIFO + MAC-chain model fed by the controller outputs.
module tb_mvm_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a [7:0];
  logic [7:0] in_b;
  logic       a_wren;
  logic       b_wren;
  logic [7:0] a_fifo_in [7:0];
  logic [7:0] b_fifo_in;
  logic [7:0] a_rden;
  logic       b_rden;
  logic       clr;
  logic       busy;
  logic       done;
  logic       result_valid;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  tb_a [8][8];
  logic [7:0]  tb_b [8];
  logic [23:0] exp_out [8];

  always #5 clk = ~clk;

  mvm_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .a_wren       (a_wren),
    .b_wren       (b_wren),
    .a_fifo_in    (a_fifo_in),
    .b_fifo_in    (b_fifo_in),
    .a_rden       (a_rden),
    .b_rden       (b_rden),
    .clr          (clr),
    .busy         (busy),
    .done         (done),
    .result_valid (result_valid)
  );

  // Datapath model: FIFOs written by wren, lane i pairs its k-th A read with B[k].
  logic [7:0]  m_fa [8][8];
  logic [7:0]  m_fb [8];
  logic [3:0]  m_wp;
  logic [3:0]  m_arp [8];
  logic [23:0] m_acc [8];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      m_wp <= 4'd0;
      for (int i = 0; i < 8; i++) begin
        m_arp[i] <= 4'd0;
        m_acc[i] <= 24'd0;
      end
    end else begin
      if (a_wren && !m_wp[3]) begin
        for (int i = 0; i < 8; i++) m_fa[i][m_wp[2:0]] <= a_fifo_in[i];
      end
      if (b_wren && !m_wp[3]) m_fb[m_wp[2:0]] <= b_fifo_in;
      if (a_wren) m_wp <= m_wp + 4'd1;
      for (int i = 0; i < 8; i++) begin
        if (a_rden[i]) begin
          if (!m_arp[i][3])
            m_acc[i] <= m_acc[i] + 24'(m_fa[i][m_arp[i][2:0]]) * 24'(m_fb[m_arp[i][2:0]]);
          m_arp[i] <= m_arp[i] + 4'd1;
        end
      end
    end
  end

  task automatic drive_beat(input int beat);
    for (int i = 0; i < 8; i++) in_a[i] = (beat < 8) ? tb_a[i][beat] : 8'hEE;
    in_b = (beat < 8) ? tb_b[beat] : 8'hEE;
  endtask

  // One job; n = edges since start was driven. Unstalled: CLEAR n=1, LOAD 2..9, RUN 10..24, DRAIN 25..26, DONE 27.
  task automatic run_job(input string name, input bit stall, input bit glitch, input int exp_done);
    int beat = 0, wr = 0, brd = 0, clrs = 0, done_at = 0, t;
    int ard [8];
    bit hs, skip;
    logic [14:0] obs, exp_v;
    for (int i = 0; i < 8; i++) ard[i] = 0;
    start = 1'b1;
    in_valid = 1'b1;
    drive_beat(0);
    for (int n = 1; n <= exp_done + 2; n++) begin
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) beat++;
      skip = stall && hs;
      start = glitch && (n == 5 || n == 15);
      in_valid = !skip;
      drive_beat(beat);
      if (a_wren) wr++;
      if (b_rden) brd++;
      if (clr) clrs++;
      for (int i = 0; i < 8; i++) if (a_rden[i]) ard[i]++;
      if (done && done_at == 0) done_at = n;
      n_cmp++;
      if (busy !== (n <= exp_done)) begin
        n_err++;
        $display("FAIL %s busy n=%0d: got %b want %b", name, n, busy, (n <= exp_done));
      end
      if (!stall) begin
        t = n - 10;
        exp_v[14] = (n == 1);
        exp_v[13] = (n >= 2 && n <= 9);
        exp_v[12] = (n >= 3 && n <= 10);
        exp_v[11] = (n >= 3 && n <= 10);
        exp_v[10] = (t >= 0 && t < 8);
        for (int i = 0; i < 8; i++) exp_v[2+i] = (t >= i && t < i + 8);
        exp_v[1] = (n == 27);
        exp_v[0] = (n >= 27);
        obs = {clr, in_ready, a_wren, b_wren, b_rden, a_rden, done, result_valid};
        n_cmp++;
        if (obs !== exp_v) begin
          n_err++;
          $display("FAIL %s timing n=%0d: got %h want %h", name, n, obs, exp_v);
        end
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (done_at != exp_done) begin
      n_err++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, done_at, exp_done);
    end
    n_cmp++;
    if (wr != 8) begin
      n_err++;
      $display("FAIL %s wren_count: got %0d want 8", name, wr);
    end
    n_cmp++;
    if (brd != 8) begin
      n_err++;
      $display("FAIL %s b_rden_count: got %0d want 8", name, brd);
    end
    n_cmp++;
    if (clrs != 1) begin
      n_err++;
      $display("FAIL %s clr_count: got %0d want 1", name, clrs);
    end
    n_cmp++;
    if (result_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s result_valid_idle: got %b want 1", name, result_valid);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (ard[i] != 8) begin
        n_err++;
        $display("FAIL %s a_rden_count lane %0d: got %0d want 8", name, i, ard[i]);
      end
      n_cmp++;
      if (m_acc[i] !== exp_out[i]) begin
        n_err++;
        $display("FAIL %s out lane %0d: got %0d want %0d", name, i, m_acc[i], exp_out[i]);
      end
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (m_fb[k] !== tb_b[k]) begin
        n_err++;
        $display("FAIL %s b_order k=%0d: got %h want %h", name, k, m_fb[k], tb_b[k]);
      end
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (m_fa[i][k] !== tb_a[i][k]) begin
          n_err++;
          $display("FAIL %s a_order i=%0d k=%0d: got %h want %h", name, i, k, m_fa[i][k], tb_a[i][k]);
        end
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    logic nz;
    nz = in_ready | a_wren | b_wren | (|a_rden) | b_rden | clr | busy | done | result_valid | (|b_fifo_in);
    for (int i = 0; i < 8; i++) nz = nz | (|a_fifo_in[i]);
    n_cmp++;
    if (nz !== 1'b0) begin
      n_err++;
      $display("FAIL %s outputs_zero: got %b want 0", name, nz);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    drive_beat(8);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("reset_release");
  endtask

  task automatic test_reset_mid_job();
    for (int i = 0; i < 8; i++) for (int k = 0; k < 8; k++) tb_a[i][k] = 8'(i + k + 1);
    start = 1'b1;
    in_valid = 1'b1;
    drive_beat(0);
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (n >= 2) drive_beat(n - 1);
    end
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid pre: busy %b in_ready %b want 1 1", busy, in_ready);
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_async");
    @(posedge clk);
    #1;
    check_all_zero("reset_mid_edge");
    #3 rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({a_wren, in_ready, busy} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_mid idle n=%0d: got %b want 000", n, {a_wren, in_ready, busy});
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full_job();
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) tb_a[i][k] = 8'(i + k);
      tb_b[i] = 8'd1;
      exp_out[i] = 24'(8 * i + 28);
    end
    run_job("full_job", 1'b0, 1'b0, 27);
  endtask

  task automatic test_host_stalls();
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) tb_a[i][k] = 8'(i + k);
      tb_b[i] = 8'(i + 1);
      exp_out[i] = 24'(36 * i + 168);
    end
    run_job("stalls", 1'b1, 1'b0, 34);
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) tb_a[i][k] = 8'(2 * i);
      tb_b[i] = 8'(3);
      exp_out[i] = 24'(48 * i);
    end
    run_job("start_ignored", 1'b0, 1'b1, 27);
  endtask

  task automatic test_max_values();
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) tb_a[i][k] = 8'hFF;
      tb_b[i] = 8'hFF;
      exp_out[i] = 24'd520200;
    end
    run_job("max_values", 1'b0, 1'b0, 27);
  endtask

  initial begin
    test_reset();
    test_reset_mid_job();
    test_full_job();
    test_host_stalls();
    test_start_ignored();
    test_max_values();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
